secuenciador_cuenta1: RTL and testbench
=======================================

Name: secuenciador_cuenta1

Overview:
- Sequencer placed directly in front of the one-counting block (3-bit Valor/start in, 4-bit Cuenta/fin out).
- Buffers 3-bit words from a producer in a small FIFO and issues them to the counter one at a time.
- Waits for each counting operation to complete, captures Cuenta, and keeps a running total of ones and a count of processed words.

Parameters:
- PROF, 4, FIFO depth in words; power of 2, at least 2.
- ANCHO_ACUM, 8, width of total and num.
- TIMEOUT, 16, cycles allowed per operation; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dato  in  3  word from producer.
- dato_valido  in  1  producer offers dato.
- listo  out  1  FIFO not full; a push happens when dato_valido && listo.
- valor  out  3  drives the counter's Valor input.
- start  out  1  drives the counter's start input.
- cuenta  in  4  counter's Cuenta output.
- fin  in  1  counter's fin output; high when the counter is idle or done.
- resultado  out  4  last captured count.
- res_valido  out  1  one-cycle pulse when resultado updates.
- total  out  ANCHO_ACUM  sum of all captured counts.
- num  out  ANCHO_ACUM  number of words completed.
- ocupado  out  1  FSM not in REPOSO, or FIFO not empty.
- error  out  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous) values:
  - FIFO emptied, so listo=1.
  - FSM in REPOSO.
  - valor=0, start=0, resultado=0, res_valido=0, total=0, num=0, ocupado=0, error=0.
- FIFO:
  - Push at the edge when dato_valido && listo.
  - Pop is driven by the FSM.
  - Push and pop in the same cycle are both legal when not full.
  - When full, listo=0 and no push occurs, even if a pop happens that cycle; listo rises the following cycle.
  - Words leave in arrival order.
- FSM states:
  - REPOSO: if FIFO not empty and fin==1, pop the head into the valor register and go to LANZA. The fin gate prevents launching while a counter operation left over from before a reset is still running.
  - LANZA: start=1 for exactly this one cycle; go to ESPERA_BAJA.
  - ESPERA_BAJA: wait for fin==0, then go to ESPERA_ALTA.
  - ESPERA_ALTA: when fin==1, register resultado<=cuenta, pulse res_valido, add total+=cuenta (zero-extended), increment num, then go to REPOSO.
- valor is held stable from LANZA until the next pop.
- Latency:
  - Push at edge N → start high in cycle N+2.
  - fin sampled high at edge M → resultado, res_valido, total and num visible after edge M.
  - Minimum turnaround between consecutive start pulses is 4 cycles plus the counter's busy time.
- Arithmetic: total and num wrap modulo 2^ANCHO_ACUM with no saturation. cuenta is accumulated as given, with no range check.
- Reset mid-operation: everything returns to reset values. The counter has no reset, so REPOSO blocks the next launch until fin==1.
- start is never asserted outside LANZA.

Optional Feature:
- Macro: SECUENCIADOR_TIMEOUT_EN.
- When defined:
  - A cycle counter runs during ESPERA_BAJA and ESPERA_ALTA, cleared on entering LANZA.
  - On reaching TIMEOUT: error<=1 (sticky until reset), FSM goes to REPOSO, the result is discarded, and num and total are unchanged.
- When undefined:
  - The FSM waits indefinitely.
  - error is constant 0 and there is no timer logic.

Decomposition:
- Shared include file secuenciador_defs.v holds:
  - state encodings for REPOSO, LANZA, ESPERA_BAJA, ESPERA_ALTA (2 bits);
  - default values for PROF, ANCHO_ACUM and TIMEOUT.
- One sub-module, fifo_valores, parameterised by PROF:
  - 3-bit data, push/pop;
  - outputs lleno, vacio and the head word;
  - asynchronous, active-high reset.
- The FSM and accumulators stay in the top module.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert reset during ESPERA_ALTA.
  - Response: all outputs go to their reset values immediately and listo=1.
  - Stimulus: release reset with fin=0 and data queued.
  - Response: no start pulse until fin=1.
- Single word:
  - Stimulus: dato=3'b101; counter model drops fin for 4 cycles.
  - Response: one start pulse with valor=5; resultado=2 with a one-cycle res_valido; total=2; num=1.
- Burst, PROF=4:
  - Stimulus: push 7,0,1,6,3 back-to-back.
  - Response: listo=0 after 4 words are queued; the fifth word is accepted later; results arrive in order 3,0,1,2,2; total=8; num=5.
- Wrap, ANCHO_ACUM=4:
  - Stimulus: six words of 7.
  - Response: total=18 mod 16=2; num=6.
- Timeout, macro defined, TIMEOUT=16:
  - Stimulus: counter model holds fin=0 forever.
  - Response: error=1 after 16 cycles in the wait states; num unchanged; the next queued word is launched once fin=1.
- Timeout, macro undefined:
  - Stimulus: same counter model as above.
  - Response: FSM stays in ESPERA_ALTA and error=0.

Source files
------------

// File: rtl/secuenciador_cuenta1_pkg.sv
// Shared definitions for secuenciador_cuenta1: FSM state encoding and parameter defaults.
package secuenciador_cuenta1_pkg;

  typedef enum logic [1:0] {
    REPOSO      = 2'd0,
    LANZA       = 2'd1,
    ESPERA_BAJA = 2'd2,
    ESPERA_ALTA = 2'd3
  } estado_t;

  localparam int PROF_DEF       = 4;
  localparam int ANCHO_ACUM_DEF = 8;
  localparam int TIMEOUT_DEF    = 16;

endpackage

// File: rtl/secuenciador_cuenta1_fifo_valores.sv
// fifo_valores: small FIFO of 3-bit words with an extra wrap bit on each pointer to tell full from empty.
module fifo_valores #(
  parameter int PROF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] dato,
  output logic [2:0] cabeza,
  output logic       lleno,
  output logic       vacio
);

  localparam int AP = $clog2(PROF);

  logic [2:0] mem [PROF];
  logic [AP:0] wr_ptr, rd_ptr;
  logic        push_ok, pop_ok;

  assign push_ok = push && !lleno;
  assign pop_ok  = pop && !vacio;

  assign vacio  = (wr_ptr == rd_ptr);
  assign lleno  = (wr_ptr[AP] != rd_ptr[AP]) && (wr_ptr[AP-1:0] == rd_ptr[AP-1:0]);
  assign cabeza = mem[rd_ptr[AP-1:0]];

  // NOTE: storage is left unreset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AP-1:0]] <= dato;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/secuenciador_cuenta1.sv
// Sequencer feeding the one-counting block from a FIFO and accumulating its results.
// Optional per-operation timeout: define SECUENCIADOR_TIMEOUT_EN.
module secuenciador_cuenta1
  import secuenciador_cuenta1_pkg::*;
#(
  parameter int PROF       = PROF_DEF,
  parameter int ANCHO_ACUM = ANCHO_ACUM_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            dato,
  input  logic                  dato_valido,
  output logic                  listo,
  output logic [2:0]            valor,
  output logic                  start,
  input  logic [3:0]            cuenta,
  input  logic                  fin,
  output logic [3:0]            resultado,
  output logic                  res_valido,
  output logic [ANCHO_ACUM-1:0] total,
  output logic [ANCHO_ACUM-1:0] num,
  output logic                  ocupado,
  output logic                  error
);

  estado_t    estado, siguiente;
  logic       pop, captura;
  logic [2:0] cabeza;
  logic       lleno, vacio;

  fifo_valores #(.PROF(PROF)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (dato_valido),
    .pop    (pop),
    .dato   (dato),
    .cabeza (cabeza),
    .lleno  (lleno),
    .vacio  (vacio)
  );

  assign listo   = !lleno;
  assign start   = (estado == LANZA);
  assign ocupado = (estado != REPOSO) || !vacio;

`ifdef SECUENCIADOR_TIMEOUT_EN
  localparam int ANCHO_TMP = $clog2(TIMEOUT + 1);
  logic [ANCHO_TMP-1:0] temporizador;
  logic                 vencido;
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    siguiente = estado;
    pop       = 1'b0;
    captura   = 1'b0;
    case (estado)
      // The fin gate holds off a launch while a pre-reset operation is still running.
      REPOSO:      if (!vacio && fin) begin
                     pop       = 1'b1;
                     siguiente = LANZA;
                   end
      LANZA:       siguiente = ESPERA_BAJA;
      ESPERA_BAJA: if (!fin) siguiente = ESPERA_ALTA;
      ESPERA_ALTA: if (fin) begin
                     captura   = 1'b1;
                     siguiente = REPOSO;
                   end
      default:     siguiente = REPOSO;
    endcase
`ifdef SECUENCIADOR_TIMEOUT_EN
    vencido = ((estado == ESPERA_BAJA) || (estado == ESPERA_ALTA)) && !captura &&
              (temporizador == ANCHO_TMP'(TIMEOUT - 1));
    if (vencido) siguiente = REPOSO;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= REPOSO;
      valor      <= '0;
      resultado  <= '0;
      res_valido <= 1'b0;
      total      <= '0;
      num        <= '0;
    end else begin
      estado     <= siguiente;
      res_valido <= captura;
      if (pop) valor <= cabeza;
      if (captura) begin
        resultado <= cuenta;
        total     <= total + ANCHO_ACUM'(cuenta);
        num       <= num + 1'b1;
      end
    end
  end

`ifdef SECUENCIADOR_TIMEOUT_EN
  // Timer counts cycles spent in the wait states; a discarded result leaves total and num alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      temporizador <= '0;
      error        <= 1'b0;
    end else begin
      if (estado == LANZA)
        temporizador <= '0;
      else if ((estado == ESPERA_BAJA) || (estado == ESPERA_ALTA))
        temporizador <= temporizador + 1'b1;
      if (vencido) error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_secuenciador_cuenta1.sv
// Scoreboard bench for secuenciador_cuenta1 with a behavioural one-counter model (no reset, like the real one).
module tb_secuenciador_cuenta1;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dato;
  logic       dato_valido;
  logic       listo;
  logic [2:0] valor;
  logic       start;
  logic [3:0] cuenta = 4'd0;
  logic       fin = 1'b1;
  logic [3:0] resultado;
  logic       res_valido;
  logic [7:0] total;
  logic [7:0] num;
  logic       ocupado;
  logic       error;

  always #5 clk = ~clk;

  secuenciador_cuenta1 dut (
    .clk         (clk),
    .reset       (reset),
    .dato        (dato),
    .dato_valido (dato_valido),
    .listo       (listo),
    .valor       (valor),
    .start       (start),
    .cuenta      (cuenta),
    .fin         (fin),
    .resultado   (resultado),
    .res_valido  (res_valido),
    .total       (total),
    .num         (num),
    .ocupado     (ocupado),
    .error       (error)
  );

  // Counter model: fin drops after start for `busy` cycles; hang freezes it low.
  int         busy = 4;
  int         rem  = 0;
  logic       hang = 1'b0;
  logic [2:0] lat  = 3'd0;

  always @(posedge clk) begin
    if (start) begin
      fin <= 1'b0;
      rem <= busy - 1;
      lat <= valor;
    end else if (!fin && !hang) begin
      if (rem <= 0) begin
        fin    <= 1'b1;
        cuenta <= 4'($countones(lat));
      end else begin
        rem <= rem - 1;
      end
    end
  end

  typedef struct {
    logic [3:0] res;
    logic [7:0] tot;
    logic [7:0] n;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] exp_valor[$];
  logic [7:0] m_total = 8'd0;
  logic [7:0] m_num   = 8'd0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
    checks++;
    if (actual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nombre, actual, esperado);
    end
  endtask

  // Monitor: pops expectations whenever the DUT starts an operation or presents a result.
  logic start_prev = 1'b0;
  logic rv_prev    = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      start_prev = 1'b0;
      rv_prev    = 1'b0;
    end else begin
      if (start) begin
        check("start_one_cycle", start_prev, 1'b0);
        check("start_fin_high", fin, 1'b1);
        if (exp_valor.size() == 0) check("start_unexpected", start, 1'b0);
        else check("valor", valor, exp_valor.pop_front());
      end
      if (res_valido) begin
        check("res_valido_pulse", rv_prev, 1'b0);
        if (exp_q.size() == 0) check("res_unexpected", res_valido, 1'b0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resultado", resultado, e.res);
          check("total", total, e.tot);
          check("num", num, e.n);
        end
      end
      start_prev = start;
      rv_prev    = res_valido;
    end
  end

  task automatic push(input logic [2:0] d, input logic [3:0] pc);
    int n = 0;
    @(negedge clk);
    dato        = d;
    dato_valido = 1'b1;
    while (!listo && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!listo) check("push_timeout", listo, 1'b1);
    else begin
      @(posedge clk);
      m_total = m_total + 8'(pc);
      m_num   = m_num + 8'd1;
      exp_q.push_back('{pc, m_total, m_num});
      exp_valor.push_back(d);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    dato_valido = 1'b0;
  endtask

  task automatic drain(input int limite);
    int n = 0;
    while ((ocupado || exp_q.size() != 0) && n < limite) begin
      @(negedge clk);
      n++;
    end
    check("drain", {31'd0, ocupado || (exp_q.size() != 0)}, 32'd0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_valor.delete();
    m_total = 8'd0;
    m_num   = 8'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_listo"}, listo, 1'b1);
    check({tag, "_start"}, start, 1'b0);
    check({tag, "_valor"}, valor, 3'd0);
    check({tag, "_resultado"}, resultado, 4'd0);
    check({tag, "_res_valido"}, res_valido, 1'b0);
    check({tag, "_total"}, total, 8'd0);
    check({tag, "_num"}, num, 8'd0);
    check({tag, "_ocupado"}, ocupado, 1'b0);
    check({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    dato        = 3'd0;
    dato_valido = 1'b0;
    #12;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b0;

    // Single word: 3'b101 -> two ones; start two cycles after the push edge.
    push(3'd5, 4'd2);
    @(negedge clk);
    dato_valido = 1'b0;
    check("lat_n1_start", start, 1'b0);
    @(negedge clk);
    check("lat_n2_start", start, 1'b1);
    check("lat_n2_valor", valor, 3'd5);
    drain(200);
    check("single_resultado", resultado, 4'd2);
    check("single_total", total, 8'd2);
    check("single_num", num, 8'd1);

    // Reset during ESPERA_ALTA with a long counter operation in flight.
    busy = 30;
    push(3'd6, 4'd2);
    idle();
    n = 0;
    while (!start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_start_seen", start, 1'b1);
    repeat (3) @(negedge clk);
    check("mid_fin_low", fin, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_values("mid");
    clear_model();
    busy = 4;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Burst with fin still low: FIFO fills, nothing launches until fin rises.
    push(3'd7, 4'd3);
    push(3'd0, 4'd0);
    push(3'd1, 4'd1);
    push(3'd6, 4'd2);
    @(negedge clk);
    check("burst_full_listo", listo, 1'b0);
    check("burst_ocupado", ocupado, 1'b1);
    check("burst_no_start", {31'd0, start}, {31'd0, 1'b0});
    check("burst_fin_low", fin, 1'b0);
    push(3'd3, 4'd2);
    idle();
    drain(500);
    check("burst_total", total, 8'd8);
    check("burst_num", num, 8'd5);
    check("burst_resultado", resultado, 4'd2);

    // Counter hangs with fin low after the start pulse.
    hang = 1'b1;
    push(3'd6, 4'd2);
    idle();
    repeat (40) @(negedge clk);
`ifdef SECUENCIADOR_TIMEOUT_EN
    check("to_error", error, 1'b1);
    check("to_num", num, 8'd5);
    check("to_total", total, 8'd8);
    check("to_ocupado", ocupado, 1'b0);
    exp_q.delete();
    m_total = m_total - 8'd2;
    m_num   = m_num - 8'd1;
    push(3'd1, 4'd1);
    idle();
    repeat (5) @(negedge clk);
    check("to_blocked_ocupado", ocupado, 1'b1);
    hang = 1'b0;
    drain(200);
    check("to_after_num", num, 8'd6);
    check("to_after_total", total, 8'd9);
    check("to_sticky", error, 1'b1);
`else
    check("hang_error", error, 1'b0);
    check("hang_ocupado", ocupado, 1'b1);
    check("hang_num", num, 8'd5);
    hang = 1'b0;
    drain(200);
    check("hang_after_num", num, 8'd6);
    check("hang_after_total", total, 8'd10);
`endif

    // Accumulator wrap: 86 words of 7 -> 258 ones, total wraps to 2.
    @(negedge clk);
    #2 reset = 1'b1;
    clear_model();
    busy = 1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 86; i++) push(3'd7, 4'd3);
    idle();
    drain(3000);
    check("wrap_total", total, 8'd2);
    check("wrap_num", num, 8'd86);
    check("wrap_resultado", resultado, 4'd3);
    check("wrap_error", error, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
